// File: rtl/oh_ibufds_pkg.sv
// Shared definitions for the differential input buffer power sequencer.
// Holds the per-channel FSM state encoding and counter sizing helper.
// No ports; imported by oh_ibufds_pwrseq and oh_ibufds_pwrseq_ch.
package oh_ibufds_pkg;

  // Per-channel power sequencing states
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,  // buffer and termination disabled
    ST_TERM  = 2'd1,  // termination on, waiting for it to settle
    ST_ON    = 2'd2,  // buffer on, sync chain filling then data valid
    ST_DRAIN = 2'd3   // buffer off, termination held one more cycle
  } state_t;

  // One down-counter serves both the settle wait and the sync fill, so it
  // must hold whichever preload is larger. With legal SETTLE >= SYNC this is
  // simply clog2(SETTLE+1); the max only matters for tiny SETTLE values.
  function automatic int cnt_width(input int settle, input int sync);
    int w_settle;
    int w_sync;
    w_settle = $clog2(settle + 1);
    w_sync   = $clog2(sync + 1);
    return (w_settle > w_sync) ? w_settle : w_sync;
  endfunction

endpackage

// File: rtl/oh_ibufds_pwrseq_ch.sv
// One channel: power sequencing FSM, differential decode, sync chain.
// Latency: termination 1 edge after en, buffer +SETTLE, ready/out +SYNC more.
// No backpressure; en is a level request sampled every cycle.
// Ports: clk, nreset, i_en, i_in_p, i_in_n -> o_out, o_ready,
//        o_ibufdisable, o_intermdisable (all single bit).
module oh_ibufds_pwrseq_ch
  import oh_ibufds_pkg::*;
#(
  parameter int SETTLE  = 16,
  parameter int SYNC    = 2,
  parameter bit TERM_EN = 1'b1
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_en,
  input  logic i_in_p,
  input  logic i_in_n,
  output logic o_out,
  output logic o_ready,
  output logic o_ibufdisable,
  output logic o_intermdisable
);

  localparam int            CW        = cnt_width(SETTLE, SYNC);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);
  localparam logic [CW-1:0] SYNC_LD   = CW'(SYNC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_hold;
  logic            w_dec;
  logic [SYNC-1:0] r_sync;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    // counter saturates at zero, never wraps
    w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - CNT_ONE) : '0;
    case (r_state)
      ST_OFF: begin
        w_cnt_nxt = '0;
        if (i_en) begin
          if (TERM_EN) begin
            w_state_nxt = ST_TERM;
            w_cnt_nxt   = SETTLE_LD;
          end else begin
            w_state_nxt = ST_ON;
            w_cnt_nxt   = SYNC_LD;
          end
        end
      end
      ST_TERM: begin
        // dropping en wins over an expiring count
        if (!i_en) begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= CNT_ONE) begin
          // count of 1 means this is the SETTLE-th TERM cycle
          w_state_nxt = ST_ON;
          w_cnt_nxt   = SYNC_LD;
        end
      end
      ST_ON: begin
        if (!i_en) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: pad controls are pure functions of registered state, so
  // reset reaches the pads without waiting for a clock.
  always_comb begin
    o_ibufdisable   = 1'b1;
    o_intermdisable = 1'b1;
    o_ready         = 1'b0;
    case (r_state)
      ST_TERM: o_intermdisable = 1'b0;
      ST_ON: begin
        o_ibufdisable   = 1'b0;
        o_intermdisable = ~TERM_EN;
        o_ready         = (r_cnt == '0);
      end
      ST_DRAIN: o_intermdisable = ~TERM_EN;
      default: ;
    endcase
  end

  // Equal legs mean the pair is floating or invalid: keep the last good bit.
  assign w_dec = o_ibufdisable ? 1'b0 : ((i_in_p != i_in_n) ? i_in_p : r_hold);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_hold <= 1'b0;
      r_sync <= '0;
    end else begin
      r_hold <= w_dec;
      r_sync <= {r_sync[SYNC-2:0], w_dec};
    end
  end

  assign o_out = r_sync[SYNC-1] & o_ready;

endmodule

// File: rtl/oh_ibufds_pwrseq.sv
// Power-sequenced differential input buffer bank of N independent channels.
// Latency: en->termination 1 edge, ->buffer SETTLE edges, ->ready SETTLE+SYNC.
// No backpressure; each channel follows its own en level.
// Ports: clk, nreset (async active-low), en/in_p/in_n [N] in;
//        out/ready/ibufdisable/intermdisable [N] out.
module oh_ibufds_pwrseq
  import oh_ibufds_pkg::*;
#(
  parameter int    N         = 4,
  parameter int    SETTLE    = 16,
  parameter int    SYNC      = 2,
  parameter string DIFF_TERM = "TRUE"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] en,
  input  logic [N-1:0] in_p,
  input  logic [N-1:0] in_n,
  output logic [N-1:0] out,
  output logic [N-1:0] ready,
  output logic [N-1:0] ibufdisable,
  output logic [N-1:0] intermdisable
);

  localparam bit TERM_EN = (DIFF_TERM == "TRUE");

  for (genvar g = 0; g < N; g++) begin : g_ch
    oh_ibufds_pwrseq_ch #(
      .SETTLE  (SETTLE),
      .SYNC    (SYNC),
      .TERM_EN (TERM_EN)
    ) u_ch (
      .clk             (clk),
      .nreset          (nreset),
      .i_en            (en[g]),
      .i_in_p          (in_p[g]),
      .i_in_n          (in_n[g]),
      .o_out           (out[g]),
      .o_ready         (ready[g]),
      .o_ibufdisable   (ibufdisable[g]),
      .o_intermdisable (intermdisable[g])
    );
  end

endmodule

// File: tb/tb_oh_ibufds_pwrseq.sv
// Bench for oh_ibufds_pwrseq: timeline model of each channel checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_oh_ibufds_pwrseq;

  localparam int N      = 4;
  localparam int SETTLE = 16;
  localparam int SYNC   = 2;

  logic         clk    = 1'b0;
  logic         nreset = 1'b1;
  logic [N-1:0] en     = '0;
  logic [N-1:0] in_p   = '0;
  logic [N-1:0] in_n   = '0;
  logic [N-1:0] out;
  logic [N-1:0] ready;
  logic [N-1:0] ibufdisable;
  logic [N-1:0] intermdisable;

  int n_checks = 0;
  int n_pass   = 0;

  oh_ibufds_pwrseq #(
    .N(N), .SETTLE(SETTLE), .SYNC(SYNC), .DIFF_TERM("TRUE")
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .en            (en),
    .in_p          (in_p),
    .in_n          (in_n),
    .out           (out),
    .ready         (ready),
    .ibufdisable   (ibufdisable),
    .intermdisable (intermdisable)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_t: edges elapsed since the enable episode began (-1 when not enabled).
  // Termination on for t>=0, buffer on for t>=SETTLE, valid for t>=SETTLE+SYNC.
  int m_t     [N];
  bit m_drain [N];
  bit m_hold  [N];
  bit m_hist  [N][SYNC];   // decoded values captured at the last SYNC edges

  function automatic bit exp_ib(int c);
    return m_t[c] < SETTLE;
  endfunction
  function automatic bit exp_it(int c);
    return (m_t[c] < 0) && !m_drain[c];
  endfunction
  function automatic bit exp_rd(int c);
    return m_t[c] >= SETTLE + SYNC;
  endfunction
  function automatic bit exp_out(int c);
    return exp_rd(c) && m_hist[c][SYNC-1];
  endfunction

  initial begin
    for (int c = 0; c < N; c++) m_t[c] = -1;
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) begin
        for (int c = 0; c < N; c++) begin
          m_t[c] = -1; m_drain[c] = 1'b0; m_hold[c] = 1'b0;
          for (int j = 0; j < SYNC; j++) m_hist[c][j] = 1'b0;
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          bit d;
          d = exp_ib(c) ? 1'b0 : ((in_p[c] != in_n[c]) ? in_p[c] : m_hold[c]);
          m_hold[c] = d;
          for (int j = SYNC - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
          m_hist[c][0] = d;
          if (m_drain[c]) m_drain[c] = 1'b0;
          else if (m_t[c] < 0) begin
            if (en[c]) m_t[c] = 0;
          end else if (!en[c]) begin
            m_drain[c] = (m_t[c] >= SETTLE);
            m_t[c] = -1;
          end else if (m_t[c] < 10000) m_t[c] = m_t[c] + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkv(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  initial begin
    logic [N-1:0] e_ib, e_it, e_rd, e_out;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        e_ib[c] = exp_ib(c); e_it[c] = exp_it(c);
        e_rd[c] = exp_rd(c); e_out[c] = exp_out(c);
      end
      checkv("model ibufdisable", ibufdisable, e_ib);
      checkv("model intermdisable", intermdisable, e_it);
      checkv("model ready", ready, e_rd);
      checkv("model out", out, e_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    checkv({tag, " out"}, out, '0);
    checkv({tag, " ready"}, ready, '0);
    checkv({tag, " ibufdisable"}, ibufdisable, '1);
    checkv({tag, " intermdisable"}, intermdisable, '1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic saw_ib_low;
    logic saw_rd_high;

    #1 nreset = 1'b0;
    repeat (3) tick();
    check_reset_vals("in reset");
    nreset = 1'b1;

    // idle after release
    repeat (100) tick();
    check_reset_vals("idle 100");

    // channel 0 bring-up timing
    en[0] = 1'b1; in_p[0] = 1'b1; in_n[0] = 1'b0;
    tick();
    checkb("ch0 term on", intermdisable[0], 1'b0);
    checkb("ch0 buf off in term", ibufdisable[0], 1'b1);
    repeat (SETTLE - 1) tick();
    checkb("ch0 buf off last term cycle", ibufdisable[0], 1'b1);
    tick();
    checkb("ch0 buf on", ibufdisable[0], 1'b0);
    checkb("ch0 not ready at buf on", ready[0], 1'b0);
    tick();
    checkb("ch0 not ready fill", ready[0], 1'b0);
    tick();
    checkb("ch0 ready", ready[0], 1'b1);
    checkb("ch0 out", out[0], 1'b1);
    for (int c = 1; c < N; c++) begin
      checkb("other ch ibufdisable", ibufdisable[c], 1'b1);
      checkb("other ch intermdisable", intermdisable[c], 1'b1);
      checkb("other ch ready", ready[c], 1'b0);
    end

    // channel 1 short pulse aborts termination
    saw_ib_low = 1'b0; saw_rd_high = 1'b0;
    en[1] = 1'b1; in_p[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw_ib_low  |= ~ibufdisable[1];
      saw_rd_high |= ready[1];
    end
    checkb("ch1 term held", intermdisable[1], 1'b0);
    en[1] = 1'b0;
    tick();
    checkb("ch1 off after abort", intermdisable[1], 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_ib_low  |= ~ibufdisable[1];
      saw_rd_high |= ready[1];
    end
    checkb("ch1 buffer never enabled", saw_ib_low, 1'b0);
    checkb("ch1 never ready", saw_rd_high, 1'b0);

    // channels 2 and 3 up
    en[3:2] = 2'b11; in_p[3:2] = 2'b11; in_n[3:2] = 2'b00;
    repeat (20) tick();
    checkv("ch2/3 ready", {2'b00, ready[3:2]}, 4'b0011);
    checkv("ch2/3 out", {2'b00, out[3:2]}, 4'b0011);

    // channel 2 drain
    en[2] = 1'b0;
    tick();
    checkb("ch2 drain ready", ready[2], 1'b0);
    checkb("ch2 drain out", out[2], 1'b0);
    checkb("ch2 drain ibufdisable", ibufdisable[2], 1'b1);
    checkb("ch2 drain term kept", intermdisable[2], 1'b0);
    tick();
    checkb("ch2 off term", intermdisable[2], 1'b1);

    // channel 3 hold on invalid input, then new value
    in_p[3] = 1'b1; in_n[3] = 1'b1;
    repeat (3) tick();
    checkb("ch3 hold", out[3], 1'b1);
    in_p[3] = 1'b0; in_n[3] = 1'b1;
    tick();
    checkb("ch3 pipe 1", out[3], 1'b1);
    tick();
    checkb("ch3 new value", out[3], 1'b0);

    // async reset while all channels are on
    en = '1; in_p = 4'b1111; in_n = 4'b0000;
    repeat (20) tick();
    checkv("all ready", ready, '1);
    @(posedge clk);
    #3 nreset = 1'b0;
    #1 check_reset_vals("async reset");
    tick();
    nreset = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(23) == 0) en[c] = ~en[c];
        in_p[c] = 1'($urandom_range(1));
        in_n[c] = 1'($urandom_range(1));
      end
      if (nreset == 1'b0) begin
        if ($urandom_range(2) == 0) nreset = 1'b1;
      end else if ($urandom_range(499) == 0) begin
        nreset = 1'b0;
      end
    end
    nreset = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oh_ibufds_pwrseq.md
OH_IBUFDS_PWRSEQ -- requirements
Module: oh_ibufds_pwrseq

Interface
REQ-001 SHALL have parameter N, default 4, channel count, legal 1..32.
REQ-002 SHALL have parameter SETTLE, default 16, termination settle cycles, legal 1..255.
REQ-003 SHALL have parameter SYNC, default 2, input synchronizer depth, legal 2..4.
REQ-004 SHALL have parameter DIFF_TERM, default "TRUE", termination in use ("TRUE"/"FALSE").
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port nreset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port en  input  N  per-channel receive-enable request.
REQ-008 SHALL have port in_p  input  N  differential positive legs.
REQ-009 SHALL have port in_n  input  N  differential negative legs.
REQ-010 SHALL have port out  output  N  decoded, synchronized channel data.
REQ-011 SHALL have port ready  output  N  channel data valid.
REQ-012 SHALL have port ibufdisable  output  N  per-channel buffer disable to pad cell.
REQ-013 SHALL have port intermdisable  output  N  per-channel termination disable to pad cell.

Function
REQ-014 Each channel SHALL run an independent FSM with states OFF, TERM, ON, DRAIN.
REQ-015 OFF: ibufdisable=1, intermdisable=1, ready=0, out=0; en=1 sampled -> TERM (DIFF_TERM="TRUE") or ON (DIFF_TERM="FALSE").
REQ-016 TERM: intermdisable=0, ibufdisable=1; down-counter loaded with SETTLE on entry; state SHALL last exactly SETTLE cycles, then ON.
REQ-017 TERM with en=0 sampled SHALL go to OFF next cycle, discarding the count.
REQ-018 ON: ibufdisable=0, intermdisable=0 (1 if DIFF_TERM="FALSE"); fill counter of SYNC cycles starts on entry; ready=1 from the cycle after it expires while in ON.
REQ-019 ON with en=0 sampled SHALL go to DRAIN: ibufdisable=1, ready=0, out=0 in the same cycle as DRAIN entry.
REQ-020 DRAIN SHALL last exactly 1 cycle (termination still enabled) then OFF, regardless of en.
REQ-021 Latency: en rising sampled at edge k -> intermdisable falls after k, ibufdisable falls after k+SETTLE, ready rises after k+SETTLE+SYNC (DIFF_TERM="TRUE").
REQ-022 Decode: in_p!=in_n -> in_p; in_p==in_n (invalid/floating) -> hold previous decoded value; decoded value forced 0 while ibufdisable=1.
REQ-023 Decoded value SHALL pass through SYNC flops; out = last stage AND ready.
REQ-024 Counter width SHALL be clog2(SETTLE+1); counters SHALL not wrap, saturating at 0.
REQ-025 Channels SHALL not interact; simultaneous en changes on multiple channels SHALL each follow REQ-015..020.

Reset
REQ-026 nreset low SHALL asynchronously force all FSMs to OFF, counters to 0, sync chains and decode-hold to 0, ready=0, out=0, ibufdisable=1, intermdisable=1.
REQ-027 Reset asserted mid-TERM/ON/DRAIN SHALL abort immediately; deassertion SHALL be synchronized to clk by the instantiating level; first en sampling on the first edge after release.

Structure
REQ-028 FSM state encoding and state localparams SHALL live in shared package oh_ibufds_pkg.
REQ-029 Per-channel logic SHALL be sub-module oh_ibufds_pwrseq_ch, instantiated N times by generate loop.

Verification (N=4, SETTLE=16, SYNC=2, DIFF_TERM="TRUE")
REQ-030 Reset release, en=0 -> all outputs at reset values for 100 cycles.
REQ-031 en[0]=1 at edge 10, in_p[0]=1, in_n[0]=0 -> intermdisable[0]=0 after 10, ibufdisable[0]=0 after 26, ready[0]=1 and out[0]=1 after 28; channels 1..3 unchanged.
REQ-032 en[1] pulsed high 5 cycles -> TERM aborted, OFF after 6 cycles, ibufdisable[1] never 0, ready[1] never 1.
REQ-033 Channel 2 ready, drop en -> ready=0/out=0/ibufdisable=1 next cycle, intermdisable=1 one cycle later.
REQ-034 Channel 3 ready, drive in_p=in_n=1 -> out[3] holds prior value; then in_p=0, in_n=1 -> out[3]=0 after 2 cycles.
REQ-035 nreset asserted during ON on all channels -> outputs at reset values asynchronously, before next clk edge.
